fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 21 ++
 rtl/fetch_queue_fq_storage.sv | 40 ++++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared pipeline definitions used by the fetch queue and the
//               PC register: reset PC, NOP encoding and the buffered fetch
//               entry layout ({pc, instr}, pc in the upper 32 bits).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // pc occupies [63:32], instr occupies [31:0]
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_fq_storage.sv
`default_nettype none
// ============================================================================
// Module      : fq_storage
// Description : DEPTH x 64-bit register array holding fetch entries.
//               One synchronous write port, one combinational read port.
//               Contents are intentionally not reset.
// Ports       : clk    - rising-edge clock
//               we     - write enable
//               waddr  - write address
//               wdata  - entry to write
//               raddr  - read address
//               rdata  - entry at raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t  rdata
);

  fetch_entry_t mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fq_storage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch buffer between IF and decode. Holds
//               {pc, instr} pairs in program order; IF pushes, decode pops,
//               a redirect flush discards every buffered entry.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               flush      - discard all entries (priority over push/pop)
//               push_valid - IF offers an entry
//               push_pc    - PC of offered instruction
//               push_instr - offered instruction word
//               push_ready - queue not full
//               pop_valid  - queue not empty
//               pop_pc     - head PC (RESET_PC when empty)
//               pop_instr  - head instruction (NOP when empty)
//               pop_ready  - decode consumes head this cycle
//               count      - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] RESET_PC = fetch_queue_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push_valid,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  output logic          push_ready,
  output logic          pop_valid,
  output logic [31:0]   pop_pc,
  output logic [31:0]   pop_instr,
  input  logic          pop_ready,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop_fire;
  fetch_entry_t  wr_entry;
  fetch_entry_t  rd_entry;

  // Full/empty come from the occupancy counter: with a power-of-two depth the
  // pointers alone cannot tell full from empty.
  assign push_ready = (count != FULL_COUNT);
  assign pop_valid  = (count != '0);

  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop_valid && pop_ready;

  assign wr_entry.pc    = push_pc;
  assign wr_entry.instr = push_instr;

  fq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (push_fire && !flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Empty queue presents a NOP at the reset PC so decode never sees stale data.
  assign pop_pc    = pop_valid ? rd_entry.pc    : RESET_PC;
  assign pop_instr = pop_valid ? rd_entry.instr : NOP_INSTR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A queue-based reference
//               model tracks the buffered entries; directed scenarios are
//               followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          AW    = 2;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        push_valid;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        push_ready;
  logic        pop_valid;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic        pop_ready;
  logic [AW:0] count;

  int total = 0;
  int bad   = 0;

  logic [63:0] model_q [$];

  fetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_PC (RPC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_pc     (pop_pc),
    .pop_instr  (pop_instr),
    .pop_ready  (pop_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".count"},      64'(count),      64'(n));
    check({tag, ".pop_valid"},  64'(pop_valid),  64'(n != 0));
    check({tag, ".push_ready"}, 64'(push_ready), 64'(n != DEPTH));
    check({tag, ".pop_pc"},     64'(pop_pc),     (n != 0) ? 64'(model_q[0][63:32]) : 64'(RPC));
    check({tag, ".pop_instr"},  64'(pop_instr),  (n != 0) ? 64'(model_q[0][31:0])  : 64'h0);
  endtask

  // Drive one cycle's inputs after the falling edge, check the outputs the
  // model predicts for the current state, then advance the model across the
  // coming rising edge.
  task automatic step(input string tag, input logic fl, input logic pv,
                      input logic [31:0] pc, input logic [31:0] ins, input logic pr);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    flush      = fl;
    push_valid = pv;
    push_pc    = pc;
    push_instr = ins;
    pop_ready  = pr;
    #1;
    check_outputs(tag);
    if (fl) begin
      model_q.delete();
    end else begin
      do_pop  = pr && (model_q.size() > 0);
      do_push = pv && (model_q.size() < DEPTH);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, ins});
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".count"},      64'(count),      64'h0);
    check({tag, ".pop_valid"},  64'(pop_valid),  64'h0);
    check({tag, ".push_ready"}, 64'(push_ready), 64'h1);
    check({tag, ".pop_pc"},     64'(pop_pc),     64'(RPC));
    check({tag, ".pop_instr"},  64'(pop_instr),  64'h0);
  endtask

  initial begin
    logic [31:0] pcs [0:7];
    rst_n      = 1'b1;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_pc    = '0;
    push_instr = '0;
    pop_ready  = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream asynchronous reset with three entries buffered
    step("pre_rst0", 1'b0, 1'b1, 32'h0040_1000, 32'hAAAA_0001, 1'b0);
    step("pre_rst1", 1'b0, 1'b1, 32'h0040_1004, 32'hAAAA_0002, 1'b0);
    step("pre_rst2", 1'b0, 1'b1, 32'h0040_1008, 32'hAAAA_0003, 1'b0);
    @(negedge clk);
    push_valid = 1'b0;
    #1 check("pre_rst.count3", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    model_q.delete();
    #1 check_reset_values("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, refuse a fifth push, then drain in order
    for (int i = 0; i < 4; i++)
      step("fill", 1'b0, 1'b1, RPC + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0);
    step("fill_full", 1'b0, 1'b1, RPC + 32'h10, 32'hC0DE_0004, 1'b0);
    check("full.count", 64'(count), 64'd4);
    check("full.push_ready", 64'(push_ready), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("drain.order_pc", 64'(pop_pc), 64'(RPC + 32'(4 * i)));
    end
    idle("drained");
    check("drained.count", 64'(count), 64'h0);

    // Wrap-around: push six, pop five, interleaved
    for (int i = 0; i < 8; i++) pcs[i] = 32'h0040_2000 + 32'(4 * i);
    step("wrap_p1", 1'b0, 1'b1, pcs[0], 32'h1111_0000, 1'b0);
    step("wrap_p2", 1'b0, 1'b1, pcs[1], 32'h1111_0001, 1'b0);
    for (int i = 2; i < 6; i++)
      step("wrap_pp", 1'b0, 1'b1, pcs[i], 32'h1111_0000 + 32'(i), 1'b1);
    step("wrap_pop", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle("wrap_end");
    check("wrap.head_pc", 64'(pop_pc), 64'(pcs[5]));
    check("wrap.count1", 64'(count), 64'd1);

    // Simultaneous push and pop at count=2
    step("sim_fill", 1'b0, 1'b1, pcs[6], 32'h2222_0006, 1'b0);
    step("sim_both", 1'b0, 1'b1, pcs[7], 32'h2222_0007, 1'b1);
    idle("sim_after");
    check("sim.count2", 64'(count), 64'd2);
    check("sim.head_pc", 64'(pop_pc), 64'(pcs[6]));

    // Full boundary: pop fires, push dropped
    step("fb_fill0", 1'b0, 1'b1, 32'h0040_3000, 32'h3333_0000, 1'b0);
    step("fb_fill1", 1'b0, 1'b1, 32'h0040_3004, 32'h3333_0001, 1'b0);
    step("fb_both",  1'b0, 1'b1, 32'h0040_3008, 32'h3333_0002, 1'b1);
    idle("fb_after");
    check("fullbnd.count3", 64'(count), 64'd3);

    // Flush with concurrent push and pop
    step("flush", 1'b1, 1'b1, 32'h0040_0020, 32'h4444_0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle("post_flush");
      check("flush.no_leak_pc", 64'(pop_pc == 32'h0040_0020), 64'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom_range(0, 31) == 0),
           1'($urandom),
           32'h0040_0000 + {$urandom_range(0, 16383), 2'b00},
           $urandom,
           1'($urandom));
    end
    idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_queue
`default_nettype wire
